// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial sequence detector.
//   state_e    : controller FSM states (IDLE, ARMED, DONE)
//   cfg_t      : latched run configuration (pattern, len, overlap, target)
//   LEN_W      : width of the pattern-length field
//   len_legal  : legality test for an offered pattern length
// cfg_t is sized from the package constants; override MAX_WIDTH/CNT_WIDTH on
// the top only together with PKG_MAX_WIDTH/PKG_CNT_WIDTH here.
package seq_det_pkg;

  localparam int unsigned PKG_MAX_WIDTH = 8;
  localparam int unsigned PKG_CNT_WIDTH = 8;
  localparam int unsigned LEN_W         = $clog2(PKG_MAX_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [PKG_MAX_WIDTH-1:0] pattern;
    logic [LEN_W-1:0]         len;
    logic                     overlap;
    logic [PKG_CNT_WIDTH-1:0] target;
  } cfg_t;

  function automatic logic len_legal(input int unsigned len, input int unsigned max_w);
    return (len != 0) && (len <= max_w);
  endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Configuration, run-control, serial-data and status bundle of seq_det_ctrl.
//   master : the side that configures/feeds the detector
//   slave  : the detector itself
interface seq_det_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = PKG_MAX_WIDTH,
  parameter int unsigned CNT_WIDTH = PKG_CNT_WIDTH
);
  localparam int unsigned LW = $clog2(MAX_WIDTH + 1);

  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic [MAX_WIDTH-1:0] cfg_pattern_i;
  logic [LW-1:0]        cfg_len_i;
  logic                 cfg_overlap_i;
  logic [CNT_WIDTH-1:0] cfg_target_i;
  logic                 cfg_err_o;
  logic                 start_i;
  logic                 abort_i;
  logic                 data_valid_i;
  logic                 data_i;
  logic                 hit_o;
  logic                 done_o;
  logic                 busy_o;
  logic [CNT_WIDTH-1:0] match_cnt_o;

  modport master (
    output cfg_valid_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i, cfg_target_i,
           start_i, abort_i, data_valid_i, data_i,
    input  cfg_ready_o, cfg_err_o, hit_o, done_o, busy_o, match_cnt_o
  );

  modport slave (
    input  cfg_valid_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i, cfg_target_i,
           start_i, abort_i, data_valid_i, data_i,
    output cfg_ready_o, cfg_err_o, hit_o, done_o, busy_o, match_cnt_o
  );

endinterface

// File: rtl/seq_det_match.sv
// History shift register, fill counter and masked pattern compare.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   clear_i       : clear history and fill counter (run start)
//   beat_i        : accepted data beat this cycle
//   data_i        : serial data bit
//   pattern_i     : pattern, LSB = most recent bit
//   len_i         : pattern length (1..MAX_WIDTH)
//   overlap_i     : 1 = overlapping detection
//   match_now_o   : combinational match for the current beat
//   match_o       : registered match pulse (one cycle after the beat)
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = PKG_MAX_WIDTH,
  parameter int unsigned LW        = $clog2(MAX_WIDTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 beat_i,
  input  logic                 data_i,
  input  logic [MAX_WIDTH-1:0] pattern_i,
  input  logic [LW-1:0]        len_i,
  input  logic                 overlap_i,
  output logic                 match_now_o,
  output logic                 match_o
);

  logic [MAX_WIDTH-1:0] hist_q;
  logic [LW-1:0]        fill_q;
  logic [MAX_WIDTH:0]   window;
  logic [MAX_WIDTH-1:0] mask;
  logic                 enough;
  logic                 bits_eq;

  assign window = {hist_q, data_i};

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      mask[i] = (i < 32'(len_i));
    end
  end

  // fill_q counts beats before the current one, so len-1 already-seen beats
  // plus this beat is enough; avoids fill_q+1 overflowing LW bits.
  assign enough      = (fill_q >= (len_i - LW'(1)));
  assign bits_eq     = ((window & {1'b0, mask}) == {1'b0, pattern_i & mask});
  assign match_now_o = beat_i && enough && bits_eq;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_o <= 1'b0;
    end else begin
      match_o <= match_now_o;
      if (clear_i) begin
        hist_q <= '0;
        fill_q <= '0;
      end else if (beat_i) begin
        hist_q <= window[MAX_WIDTH-1:0];
        if (match_now_o && !overlap_i) begin
          fill_q <= '0;
        end else if (fill_q != LW'(MAX_WIDTH)) begin
          fill_q <= fill_q + LW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Serial sequence detector controller: configuration handshake, run FSM
// (IDLE -> ARMED -> DONE -> IDLE) and match counter.
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset
//   bus   : seq_det_ctrl_if.slave (cfg handshake, start/abort, serial data,
//           hit/done/busy/match_cnt status)
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = PKG_MAX_WIDTH,
  parameter int unsigned CNT_WIDTH = PKG_CNT_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  seq_det_ctrl_if.slave bus
);

  state_e               state_q, state_d;
  cfg_t                 cfg_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 done_q;
  logic                 err_q;

  logic                 is_idle;
  logic                 cfg_hs;
  logic                 cfg_ok;
  logic                 start_go;
  logic                 beat;
  logic                 match_now;
  logic                 match_q;
  logic                 final_hit;

  assign is_idle  = (state_q == ST_IDLE);
  assign cfg_hs   = bus.cfg_valid_i && is_idle;
  assign cfg_ok   = len_legal(32'(bus.cfg_len_i), MAX_WIDTH);
  assign start_go = bus.start_i && is_idle;
  // A beat coinciding with abort is dropped so it can neither hit nor finish.
  assign beat     = (state_q == ST_ARMED) && bus.data_valid_i && !bus.abort_i;

  assign final_hit = match_now && (cfg_q.target != '0)
                  && ((cnt_q + CNT_WIDTH'(1)) == cfg_q.target);

  seq_det_match #(
    .MAX_WIDTH (MAX_WIDTH)
  ) u_match (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (start_go),
    .beat_i      (beat),
    .data_i      (bus.data_i),
    .pattern_i   (cfg_q.pattern),
    .len_i       (cfg_q.len),
    .overlap_i   (cfg_q.overlap),
    .match_now_o (match_now),
    .match_o     (match_q)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start_i) state_d = ST_ARMED;
      ST_ARMED: begin
        if (bus.abort_i)     state_d = ST_IDLE;
        else if (final_hit)  state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Config is latched on the same edge that arms the run, so a simultaneous
  // cfg offer and start runs with the new configuration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q.pattern <= '0;
      cfg_q.len     <= LEN_W'(1);
      cfg_q.overlap <= 1'b1;
      cfg_q.target  <= '0;
      err_q         <= 1'b0;
    end else begin
      err_q <= cfg_hs && !cfg_ok;
      if (cfg_hs && cfg_ok) begin
        cfg_q.pattern <= bus.cfg_pattern_i;
        cfg_q.len     <= bus.cfg_len_i;
        cfg_q.overlap <= bus.cfg_overlap_i;
        cfg_q.target  <= bus.cfg_target_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= final_hit;
      if (start_go) begin
        cnt_q <= '0;
      end else if (match_now) begin
        // Free-running (target 0) runs saturate; targeted runs stop at target.
        if (cfg_q.target != '0 || cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.cfg_ready_o = is_idle;
  assign bus.cfg_err_o   = err_q;
  assign bus.hit_o       = match_q;
  assign bus.done_o      = done_q;
  assign bus.busy_o      = (state_q == ST_ARMED);
  assign bus.match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: a bit-list reference model compared
// against every DUT output each cycle, plus directed scenario expectations.
module tb_seq_det_ctrl;
  import seq_det_pkg::*;

  localparam int unsigned MW = 8;
  localparam int unsigned CW = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned hit_seen = 0;
  int unsigned done_seen = 0;
  int unsigned err_seen = 0;

  seq_det_ctrl_if #(.MAX_WIDTH(MW), .CNT_WIDTH(CW)) bus ();

  seq_det_ctrl #(.MAX_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (spec-level) ----------------
  int   m_state = 0;          // 0 idle, 1 armed, 2 done
  logic [7:0] m_pat = '0;
  int   m_len = 1;
  bit   m_ovl = 1'b1;
  int   m_tgt = 0;
  bit   m_hist[$];            // every accepted beat of the run, oldest first
  int   m_fresh = 0;          // beats since run start or last non-overlap match
  int   m_cnt = 0;
  bit   e_hit = 0, e_done = 0, e_err = 0;

  function automatic bit window_matches();
    int n = m_hist.size();
    for (int k = 0; k < m_len; k++)
      if (m_hist[n - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk_i or posedge rst_i);
    if (rst_i) begin
      m_state = 0; m_pat = '0; m_len = 1; m_ovl = 1'b1; m_tgt = 0;
      m_hist.delete(); m_fresh = 0; m_cnt = 0;
      e_hit = 0; e_done = 0; e_err = 0;
    end else begin
      e_hit = 0; e_done = 0; e_err = 0;
      case (m_state)
        0: begin
          if (bus.cfg_valid_i) begin
            if (bus.cfg_len_i >= 1 && bus.cfg_len_i <= MW) begin
              m_pat = bus.cfg_pattern_i; m_len = int'(bus.cfg_len_i);
              m_ovl = bus.cfg_overlap_i; m_tgt = int'(bus.cfg_target_i);
            end else e_err = 1;
          end
          if (bus.start_i) begin
            m_state = 1; m_hist.delete(); m_fresh = 0; m_cnt = 0;
          end
        end
        1: begin
          if (bus.abort_i) m_state = 0;
          else if (bus.data_valid_i) begin
            m_hist.push_back(bus.data_i);
            m_fresh++;
            if (m_fresh >= m_len && window_matches()) begin
              e_hit = 1;
              if (!m_ovl) m_fresh = 0;
              if (m_tgt == 0) begin
                if (m_cnt < 255) m_cnt++;
              end else begin
                m_cnt++;
                if (m_cnt == m_tgt) begin e_done = 1; m_state = 2; end
              end
            end
          end
        end
        default: m_state = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge clk_i);
    #2;
    chk("hit_o",       bus.hit_o,       e_hit);
    chk("done_o",      bus.done_o,      e_done);
    chk("cfg_err_o",   bus.cfg_err_o,   e_err);
    chk("busy_o",      bus.busy_o,      m_state == 1);
    chk("cfg_ready_o", bus.cfg_ready_o, m_state == 0);
    chk("match_cnt_o", bus.match_cnt_o, m_cnt);
    if (bus.hit_o)     hit_seen++;
    if (bus.done_o)    done_seen++;
    if (bus.cfg_err_o) err_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic offer_cfg(input logic [7:0] p, input logic [3:0] l, input bit o,
                           input logic [7:0] t, input bit st);
    bus.cfg_valid_i = 1'b1; bus.cfg_pattern_i = p; bus.cfg_len_i = l;
    bus.cfg_overlap_i = o;  bus.cfg_target_i = t;  bus.start_i = st;
    @(negedge clk_i);
    bus.cfg_valid_i = 1'b0; bus.start_i = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1; @(negedge clk_i); bus.start_i = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort_i = 1'b1; @(negedge clk_i); bus.abort_i = 1'b0;
  endtask

  // Sends bits[n-1] first (leftmost character of a written stream first).
  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.data_valid_i = 1'b1; bus.data_i = bits[i];
      @(negedge clk_i);
    end
    bus.data_valid_i = 1'b0; bus.data_i = 1'b0;
  endtask

  int unsigned h0, d0, e0;

  initial begin
    bus.cfg_valid_i = 0; bus.cfg_pattern_i = '0; bus.cfg_len_i = '0;
    bus.cfg_overlap_i = 0; bus.cfg_target_i = '0; bus.start_i = 0;
    bus.abort_i = 0; bus.data_valid_i = 0; bus.data_i = 0;
    rst_i = 1'b1;
    idle(3);
    chk("reset hit",   bus.hit_o, 0);
    chk("reset busy",  bus.busy_o, 0);
    chk("reset cnt",   bus.match_cnt_o, 0);
    chk("reset ready", bus.cfg_ready_o, 1);
    rst_i = 1'b0;
    idle(1);

    // Overlap, 10110/5, start re-pulsed mid-run must be ignored.
    offer_cfg(8'b10110, 4'd5, 1'b1, 8'd0, 1'b0);
    pulse_start();
    h0 = hit_seen;
    send(32'b10110, 5);
    pulse_start();
    send(32'b10110, 5);
    idle(2);
    chk("s1 hits", hit_seen - h0, 2);
    chk("s1 cnt",  bus.match_cnt_o, 2);
    pulse_abort();
    idle(2);
    chk("s1 busy after abort", bus.busy_o, 0);
    chk("s1 cnt held",         bus.match_cnt_o, 2);
    pulse_abort();             // abort in IDLE: no effect

    // 101/3 overlap vs non-overlap; cfg + start together.
    offer_cfg(8'b101, 4'd3, 1'b1, 8'd0, 1'b1);
    h0 = hit_seen;
    send(32'b10101, 5);
    idle(2);
    chk("s2 ovl hits", hit_seen - h0, 2);
    pulse_abort();
    offer_cfg(8'b101, 4'd3, 1'b0, 8'd0, 1'b1);
    h0 = hit_seen;
    send(32'b10101, 5);
    idle(2);
    chk("s2 novl hits", hit_seen - h0, 1);
    chk("s2 novl cnt",  bus.match_cnt_o, 1);
    pulse_abort();

    // Target 3, 11/2 overlap.
    offer_cfg(8'b11, 4'd2, 1'b1, 8'd3, 1'b1);
    h0 = hit_seen; d0 = done_seen;
    send(32'b1111, 4);
    chk("s3 busy after done", bus.busy_o, 0);
    idle(2);
    chk("s3 hits",  hit_seen - h0, 3);
    chk("s3 done",  done_seen - d0, 1);
    chk("s3 cnt",   bus.match_cnt_o, 3);
    chk("s3 ready", bus.cfg_ready_o, 1);

    // Illegal lengths 0 and 9; previous 11/2 config still detects.
    e0 = err_seen;
    offer_cfg(8'h00, 4'd0, 1'b0, 8'd1, 1'b0);
    offer_cfg(8'hFF, 4'd9, 1'b0, 8'd1, 1'b0);
    idle(1);
    chk("s4 errs", err_seen - e0, 2);
    pulse_start();
    h0 = hit_seen;
    send(32'b011, 3);
    idle(2);
    chk("s4 hits", hit_seen - h0, 1);
    chk("s4 cnt",  bus.match_cnt_o, 1);
    pulse_abort();

    // 00000/5: fill gating, then abort with a matching beat.
    offer_cfg(8'b00000, 4'd5, 1'b1, 8'd0, 1'b1);
    h0 = hit_seen;
    send(32'b0, 4);
    idle(2);
    chk("s5 no early hit", hit_seen - h0, 0);
    send(32'b0, 1);
    idle(2);
    chk("s5 fifth hit", hit_seen - h0, 1);
    bus.abort_i = 1'b1; bus.data_valid_i = 1'b1; bus.data_i = 1'b0;
    @(negedge clk_i);
    bus.abort_i = 1'b0; bus.data_valid_i = 1'b0;
    idle(2);
    chk("s5 abort no hit", hit_seen - h0, 1);
    chk("s5 abort cnt",    bus.match_cnt_o, 1);

    // Full-width pattern, non-overlap.
    offer_cfg(8'hA5, 4'd8, 1'b0, 8'd0, 1'b1);
    h0 = hit_seen;
    send(32'hA5A5, 16);
    idle(2);
    chk("s6 full-width hits", hit_seen - h0, 2);
    pulse_abort();

    // Reset mid-run.
    offer_cfg(8'b11, 4'd2, 1'b1, 8'd0, 1'b1);
    send(32'b111, 3);
    #3 rst_i = 1'b1;
    #1;
    chk("s7 rst hit",  bus.hit_o, 0);
    chk("s7 rst done", bus.done_o, 0);
    chk("s7 rst busy", bus.busy_o, 0);
    chk("s7 rst err",  bus.cfg_err_o, 0);
    chk("s7 rst cnt",  bus.match_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(1);
    offer_cfg(8'b11, 4'd2, 1'b1, 8'd0, 1'b1);
    h0 = hit_seen;
    send(32'b11, 2);
    idle(2);
    chk("s7 restart hits", hit_seen - h0, 1);
    chk("s7 restart cnt",  bus.match_cnt_o, 1);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
